// File: rtl/cla_pkg.sv
// Shared constants, per-stage control record and the 4-bit lookahead group
// function used by the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GRP = 4;

    // Control half of a pipeline stage; the sum and operand bits live in
    // WIDTH-sized arrays next to it in the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } cla_stage_t;

    // Returns {carry_out, sum[3:0]} for one 4-bit group with full lookahead.
    function automatic logic [CLA_GRP:0] cla_grp_add(input logic [CLA_GRP-1:0] a4,
                                                     input logic [CLA_GRP-1:0] b4,
                                                     input logic               c);
        logic [CLA_GRP-1:0] g;
        logic [CLA_GRP-1:0] p;
        logic [CLA_GRP:0]   cv;
        g     = a4 & b4;
        p     = a4 ^ b4;
        cv[0] = c;
        cv[1] = g[0] | (p[0] & c);
        cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | ((&p) & c);
        return {cv[4], p ^ cv[3:0]};
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, group generate/propagate
// and carry-out for a given carry-in.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               c,
    output logic [CLA_GRP-1:0] sum,
    output logic               gout,
    output logic               pout,
    output logic               cout
);

    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] p;
    logic [CLA_GRP:0]   res;

    assign g    = a & b;
    assign p    = a ^ b;
    assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pout = &p;

    assign res  = cla_grp_add(a, b, c);
    assign sum  = res[CLA_GRP-1:0];
    assign cout = res[CLA_GRP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit adder resolving one 4-bit lookahead group per pipeline stage,
// valid/ready on both sides. Define CLA_ADDSUB_EN for the add/subtract variant.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CLA_GRP;

    // Handshake: a beat moves across an interface on a rising edge when its
    // valid and ready are both 1; valid never depends on ready, and the whole
    // pipe advances together whenever the output register is empty or drained.
    logic adv;

    logic [WIDTH-1:0] b_eff;
    logic             c0;

    cla_stage_t       st_q [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic [WIDTH-1:0] ra_q [STAGES];
    logic [WIDTH-1:0] rb_q [STAGES];
    logic             ovf_q;

    logic [WIDTH-1:0]   s_d [STAGES];
    logic [CLA_GRP-1:0] ga  [STAGES];
    logic [CLA_GRP-1:0] gb  [STAGES];
    logic [CLA_GRP-1:0] gs  [STAGES];
    logic               gc  [STAGES];
    logic               gg  [STAGES];
    logic               gp  [STAGES];
    logic               gco [STAGES];
    logic               c_d [STAGES];
    logic               c_msb;
    logic               ovf_d;

`ifdef CLA_ADDSUB_EN
    assign b_eff = b ^ {WIDTH{sub}};
    assign c0    = cin ^ sub;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = st_q[STAGES-1].valid;
    assign cout      = st_q[STAGES-1].carry;
    assign sum       = s_q[STAGES-1];
    assign ovf       = ovf_q;

    // Stage 0 eats the low group straight off the ports; later stages consume
    // the bottom nibble of the operands shifted down by the previous stage.
    always_comb begin
        ga = '{default: '0};
        gb = '{default: '0};
        gc = '{default: 1'b0};
        ga[0] = a[CLA_GRP-1:0];
        gb[0] = b_eff[CLA_GRP-1:0];
        gc[0] = c0;
        for (int k = 1; k < STAGES; k++) begin
            ga[k] = ra_q[k-1][CLA_GRP-1:0];
            gb[k] = rb_q[k-1][CLA_GRP-1:0];
            gc[k] = st_q[k-1].carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_grp
        cla_group4 u_grp (
            .a    (ga[k]),
            .b    (gb[k]),
            .c    (gc[k]),
            .sum  (gs[k]),
            .gout (gg[k]),
            .pout (gp[k]),
            .cout (gco[k])
        );
    end

    always_comb begin
        s_d = '{default: '0};
        c_d = '{default: 1'b0};
        for (int k = 0; k < STAGES; k++) begin
            c_d[k] = gg[k] | (gp[k] & gc[k]);
        end
        s_d[0] = WIDTH'(gs[0]);
        for (int k = 1; k < STAGES; k++) begin
            s_d[k] = s_q[k-1] | (WIDTH'(gs[k]) << (CLA_GRP * k));
        end
        // Carry into the MSB recovered from its sum bit; overflow is its
        // disagreement with the carry out of the MSB.
        c_msb = gs[STAGES-1][CLA_GRP-1] ^ ga[STAGES-1][CLA_GRP-1] ^ gb[STAGES-1][CLA_GRP-1];
        ovf_d = c_msb ^ gco[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
                s_q[k]  <= '0;
                ra_q[k] <= '0;
                rb_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            st_q[0].valid <= in_valid;
            if (in_valid) begin
                st_q[0].carry <= c_d[0];
                s_q[0]        <= s_d[0];
                ra_q[0]       <= a >> CLA_GRP;
                rb_q[0]       <= b_eff >> CLA_GRP;
            end
            for (int k = 1; k < STAGES; k++) begin
                st_q[k].valid <= st_q[k-1].valid;
                st_q[k].carry <= c_d[k];
                s_q[k]        <= s_d[k];
                ra_q[k]       <= ra_q[k-1] >> CLA_GRP;
                rb_q[k]       <= rb_q[k-1] >> CLA_GRP;
            end
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: reset, latency, carry chain,
// back-pressure and mid-stream reset, checked against a scoreboard queue.
module tb_pipelined_cla_adder;

    localparam int W      = 16;
    localparam int STAGES = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    bit           lat_chk = 0;
    bit           bp_en   = 0;
    bit           rdy_chk = 0;

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_ADDSUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: integer arithmetic, returns {cout, ovf, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        longint ux, uy, sx, sy, ci, t, st, lim;
        logic   co, ov;
        logic [63:0] tv;
        ux  = longint'(x);
        uy  = longint'(y);
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ci  = c ? 64'sd1 : 64'sd0;
        lim = longint'(1) << (W - 1);
        if (s) begin
            t  = ux - uy - ci;
            st = sx - sy - ci;
            co = (t >= 0);
        end else begin
            t  = ux + uy + ci;
            st = sx + sy + ci;
            co = (t >= (longint'(1) << W));
        end
        ov = (st > lim - 1) || (st < -lim);
        tv = t;
        return {co, ov, tv[W-1:0]};
    endfunction

    // driver tasks
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input logic ts);
        int n;
        @(negedge clk);
        #1;
        a        = ta;
        b        = tbv;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_wait", in_ready, 1'b1);
        if (in_ready === 1'b1) begin
            exp_q.push_back(model(ta, tbv, tc, ts));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // out_ready pattern 1,0,0,1 while back-pressure is on
    initial begin
        int         idx;
        logic [3:0] pat;
        idx       = 0;
        pat       = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_en) begin
                out_ready = pat[idx % 4];
                idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // scoreboard
    initial begin
        logic [W+1:0] expv;
        int           t0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (rdy_chk) check("in_ready_adv", in_ready, !out_valid || out_ready);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", out_valid, 1'b0);
                    end else begin
                        expv = exp_q[0];
                        check("result", {cout, ovf, sum}, expv);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            t0 = acc_q.pop_front();
                            if (lat_chk) check("latency", cyc - t0, STAGES);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sub      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_comb", in_ready, 1'b1);
        check("rst_out_valid_held", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        lat_chk = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        drain();

        lat_chk = 1'b0;
        bp_en   = 1'b1;
        rdy_chk = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();
        bp_en   = 1'b0;
        rdy_chk = 1'b0;

        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, 1'b1, 1'b0);
        send(16'hFFF0, 16'h0010, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        check("no_ghost_after_reset", out_valid, 1'b0);
        lat_chk = 1'b1;
        send(16'hABCD, 16'h0101, 1'b1, 1'b0);
        drain();

`ifdef CLA_ADDSUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h1000, 16'h0FFF, 1'b1, 1'b1);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
